// File: rtl/pool_result_writer.sv
// Pooled-result writer: buffers results from the pooling pipeline in a 2-entry FIFO
// and drains them to the output feature-map buffer at sequential addresses.
module pool_result_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_pool,
  input  logic [2:0]        array_dim,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic [1:0][DATA_W-1:0] fifo_mem;
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             fifo_cnt;
  logic [3:0]             n_exp, accept_cnt, write_cnt;
  logic [ADDR_W-1:0]      base_q;
  logic                   err_q;

  logic fifo_empty, fifo_full, active, pop, push, drop;
  logic dim_legal, start_ok, start_bad, col_vld;
  logic [3:0] n_of_dim;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign active     = (state == COLLECT) || (state == DRAIN);

  assign dim_legal  = (array_dim == 3'd3) || (array_dim == 3'd4) || (array_dim == 3'd5);
  // dim 3 uses padded edge windows, so it produces the same 2x2 output as dim 4
  assign n_of_dim   = (array_dim == 3'd5) ? 4'd9 : 4'd4;
  assign start_ok   = (state == IDLE) && start_pool && dim_legal;
  assign start_bad  = (state == IDLE) && start_pool && !dim_legal;

  assign pop     = active && !fifo_empty && mem_ready;
  assign col_vld = (state == COLLECT) && res_valid;
  // a full FIFO still accepts when the head leaves on the same edge
  assign push    = col_vld && (accept_cnt != n_exp) && !(fifo_full && !pop);
  assign drop    = col_vld && !push;

  assign wr_en   = pop;
  assign wr_addr = base_q + ADDR_W'(write_cnt);
  assign wr_data = fifo_mem[rd_ptr];
  assign busy    = active;
  assign done    = (state == FINISH);
  assign err     = err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = COLLECT;
      COLLECT: if (accept_cnt == n_exp) state_nxt = DRAIN;
      DRAIN:   if ((write_cnt == n_exp) && fifo_empty) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_exp      <= '0;
      base_q     <= '0;
      accept_cnt <= '0;
      write_cnt  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        n_exp      <= n_of_dim;
        base_q     <= base_addr;
        accept_cnt <= '0;
        write_cnt  <= '0;
        err_q      <= 1'b0;
      end else begin
        if (push)              accept_cnt <= accept_cnt + 4'd1;
        if (pop)               write_cnt  <= write_cnt + 4'd1;
        if (start_bad || drop) err_q      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fifo_mem <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= res_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
